rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-requester round-robin arbiter with hold-and-preempt behaviour, producing a registered one-hot grant vector. It sits directly upstream of the one-hot-to-BCD converter: `grant` feeds its 8-bit one-hot input, so the converter's BCD output is the index of the current owner. A hold-time limit keeps any single requester from starving the others.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive cycles one owner keeps the grant while another request is pending. Legal range is 1..255.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: request lines; bit i is requester i. Level-sensitive.
- `grant`  out  8: registered one-hot grant, or all-zero when idle. Never more than one bit set.
- `valid`  out  1: registered; equals `|grant`.
- `hold_cnt`  out  8: registered count of cycles the current owner has held the grant, starting at 0 on the first grant cycle.

## Operation
- State machine has two states:
  - IDLE: `grant` = 0.
  - OWNED: exactly one `grant` bit set.
- Pointer `ptr` (3 bits) gives the highest-priority index for the next arbitration. Search order is ptr, ptr+1, …, ptr+7, mod 8.
- Arbitration in IDLE:
  - If `req` ≠ 0, grant the first set bit in search order.
  - Set `ptr` = winner+1 mod 8 and clear `hold_cnt`.
  - Go to OWNED.
- OWNED, owner's `req` low (release):
  - Re-arbitrate among the remaining requests, with search starting at `ptr`.
  - If no other request is pending, go to IDLE.
  - There is no dead cycle between owners.
- OWNED, owner's `req` high, other requests pending, and `hold_cnt` = MAX_HOLD−1 (preempt):
  - Re-arbitrate excluding the owner.
  - The new owner gets the grant next cycle and `hold_cnt` clears.
- OWNED, owner's `req` high, no other request pending:
  - Keep the grant.
  - `hold_cnt` saturates at MAX_HOLD−1. It does not wrap.
- Otherwise, keep the grant and increment `hold_cnt`.
- `ptr` updates only when a new grant is issued.
- Release and preempt in the same cycle: release takes precedence. The result is identical either way, since the owner is excluded in both cases.

## Timing
- Reset (async assert, synchronous deassert handled externally): `grant` = 8'h00, `valid` = 0, `hold_cnt` = 0, `ptr` = 0, state IDLE. Effect is immediate on `rst_n` low.
- Latency is 1 cycle: `req` sampled at edge n drives `grant` after edge n.
- Owner release at edge n gives the next owner's grant after edge n.
- Reset asserted mid-ownership drops `grant` to 0 at once. The first grant after reset searches from index 0.
- Requests that pulse for less than one cycle between edges are not seen.

## Structure
- Shared package `arb_pkg`:
  - `localparam NUM_REQ = 8`
  - `localparam IDX_W = 3`
  - state enum `{ARB_IDLE, ARB_OWNED}`
- Sub-module `rr_pick8`, purely combinational. Inputs are an 8-bit candidate vector and a 3-bit start index. Outputs are `found` plus a one-hot `pick` and 3-bit `idx`. Implement it as a rotate, then priority-encode, then rotate back.
- The top holds the state register, `ptr`, `hold_cnt` and the grant register. It calls `rr_pick8` with candidates = `req` masked by `~grant` for release and preempt, or plain `req` in IDLE.

## Test plan
- **Reset and single request:** hold `rst_n` low, then release it and drive `req` = 8'h10. Required: `grant` = 8'h00 during reset, then 8'h10 one cycle later with `valid` = 1. Downstream BCD reads 4.
- **Rotation:** drive `req` = 8'h81 continuously with MAX_HOLD = 1. Required: `grant` alternates 8'h01, 8'h80, 8'h01, … every cycle.
- **Release handover:** owner 2 holds, `req` = 8'h0C. Drop bit 2. Required: the next cycle `grant` = 8'h08 with `hold_cnt` = 0, and no zero cycle in between.
- **Preemption:** MAX_HOLD = 4, `req` = 8'h03 held, owner 0. Required: owner 1 is granted after exactly 4 owned cycles, then owner 0 after 4 more.
- **Saturation and idle:** lone requester 5 held for 20 cycles. Required: `grant` stays 8'h20 and `hold_cnt` stops at MAX_HOLD−1. Then `req` = 0 gives `grant` = 0 next cycle.
- **Reset mid-ownership:** assert `rst_n` low mid-ownership. Required: `grant` = 0 asynchronously. After release with `req` = 8'hFF, `grant` = 8'h01.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWNED
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter8_if;
    import arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic               valid;
    logic [7:0]         hold_cnt;

    modport master (output req, input grant, input valid, input hold_cnt);
    modport slave  (input req, output grant, output valid, output hold_cnt);

endinterface

// File: rtl/rr_arbiter8_pick8.sv
// Combinational round-robin picker: first set candidate at or after i_start, mod 8.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_cand,
    input  logic [IDX_W-1:0]   i_start,
    output logic               o_found,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;

    // Rotate so that i_start lands at bit 0.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rot[i] = i_cand[IDX_W'(i) + i_start];
        end
    end

    // Priority-encode the rotated vector; descending loop leaves the lowest set bit.
    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    // Rotate back: offset plus start wraps naturally in IDX_W bits.
    assign o_found = |i_cand;
    assign o_idx   = i_start + w_off;
    assign o_pick  = {{(NUM_REQ - 1){1'b0}}, 1'b1} << o_idx;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with hold limit and registered one-hot grant.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter8_if.slave  bus
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_valid;
    logic [7:0]         r_hold_cnt;

    logic [NUM_REQ-1:0] w_cand;
    logic               w_found;
    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic               w_owner_req;
    logic               w_others;
    logic               w_switch;

    // While owned the current owner is always excluded, covering both release and preempt.
    assign w_cand      = (r_state == ARB_IDLE) ? bus.req : (bus.req & ~r_grant);
    assign w_owner_req = |(bus.req & r_grant);
    assign w_others    = |(bus.req & ~r_grant);
    assign w_switch    = !w_owner_req || (w_others && (r_hold_cnt == HOLD_LAST));

    rr_pick8 u_pick (
        .i_cand  (w_cand),
        .i_start (r_ptr),
        .o_found (w_found),
        .o_pick  (w_pick),
        .o_idx   (w_idx)
    );

    // Arbitration FSM with registered grant, valid, pointer and hold counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_state    <= ARB_OWNED;
                        r_grant    <= w_pick;
                        r_valid    <= 1'b1;
                        r_ptr      <= w_idx + IDX_W'(1);
                        r_hold_cnt <= '0;
                    end
                end
                ARB_OWNED: begin
                    if (w_switch) begin
                        if (w_found) begin
                            r_grant    <= w_pick;
                            r_valid    <= 1'b1;
                            r_ptr      <= w_idx + IDX_W'(1);
                            r_hold_cnt <= '0;
                        end else begin
                            r_state    <= ARB_IDLE;
                            r_grant    <= '0;
                            r_valid    <= 1'b0;
                            r_hold_cnt <= '0;
                        end
                    end else if (r_hold_cnt != HOLD_LAST) begin
                        // Saturates at HOLD_LAST when the owner is alone.
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant    = r_grant;
    assign bus.valid    = r_valid;
    assign bus.hold_cnt = r_hold_cnt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench: three arbiters (MAX_HOLD 15, 1, 4) share clock, reset and requests.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;

    int n_tests;
    int n_fail;

    rr_arbiter8_if if_a ();
    rr_arbiter8_if if_b ();
    rr_arbiter8_if if_c ();

    assign if_a.req = req;
    assign if_b.req = req;
    assign if_c.req = req;

    rr_arbiter8 #(.MAX_HOLD(15)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    rr_arbiter8 #(.MAX_HOLD(1))  u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    rr_arbiter8 #(.MAX_HOLD(4))  u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Index of the set bit, as the downstream BCD converter would report it.
    function automatic int onehot_idx(input logic [7:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        req     = 8'h00;
        rst_n   = 1'b0;

        // Reset and single request.
        req = 8'h10;
        step();
        step();
        check_val("rst_grant", if_a.grant, 8'h00);
        check_val("rst_valid", if_a.valid, 1'b0);
        check_val("rst_hold", if_a.hold_cnt, 8'h00);
        rst_n = 1'b1;
        step();
        check_val("single_grant", if_a.grant, 8'h10);
        check_val("single_valid", if_a.valid, 1'b1);
        check_val("single_hold", if_a.hold_cnt, 8'h00);
        check_val("single_bcd", onehot_idx(if_a.grant), 4);
        req = 8'h00;
        step();
        check_val("single_drop", if_a.grant, 8'h00);

        // Rotation with MAX_HOLD = 1.
        do_reset();
        req = 8'h81;
        for (int k = 0; k < 6; k++) begin
            step();
            check_val($sformatf("rot_%0d", k), if_b.grant, (k % 2 == 0) ? 8'h01 : 8'h80);
        end

        // Release handover: owner 2 hands to 3 with no idle cycle.
        do_reset();
        req = 8'h04;
        step();
        check_val("ho_own2", if_a.grant, 8'h04);
        req = 8'h0C;
        step();
        check_val("ho_keep2", if_a.grant, 8'h04);
        check_val("ho_keep2_hold", if_a.hold_cnt, 8'h01);
        req = 8'h08;
        step();
        check_val("ho_own3", if_a.grant, 8'h08);
        check_val("ho_own3_hold", if_a.hold_cnt, 8'h00);
        check_val("ho_own3_valid", if_a.valid, 1'b1);

        // Preemption with MAX_HOLD = 4: four cycles each, alternating 0 and 1.
        do_reset();
        req = 8'h03;
        for (int k = 0; k < 12; k++) begin
            step();
            check_val($sformatf("pre_g%0d", k), if_c.grant, ((k / 4) % 2 == 0) ? 8'h01 : 8'h02);
            check_val($sformatf("pre_h%0d", k), if_c.hold_cnt, 32'(k % 4));
        end

        // Saturation: lone requester 5, hold_cnt stops at 14.
        do_reset();
        req = 8'h20;
        for (int k = 0; k < 20; k++) begin
            step();
            check_val($sformatf("sat_g%0d", k), if_a.grant, 8'h20);
            check_val($sformatf("sat_h%0d", k), if_a.hold_cnt, (k < 14) ? 32'(k) : 32'd14);
        end
        req = 8'h00;
        step();
        check_val("sat_idle_grant", if_a.grant, 8'h00);
        check_val("sat_idle_valid", if_a.valid, 1'b0);

        // Reset mid-ownership clears grant without a clock edge.
        req = 8'h20;
        step();
        check_val("mid_own", if_a.grant, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_grant", if_a.grant, 8'h00);
        check_val("mid_rst_valid", if_a.valid, 1'b0);
        req = 8'hFF;
        #1;
        rst_n = 1'b1;
        step();
        check_val("post_rst_grant", if_a.grant, 8'h01);
        step();
        check_val("post_rst_b", if_b.grant, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
